// File: rtl/piso_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl_pkg
// Shared definitions for the serializer controller and its PISO shift register.
//   - state encoding of the controller FSM (IDLE / SHIFT / GAP)
//   - gap counter width and the largest supported idle gap
//   - gap_reload(): value loaded into the gap counter when a frame ends
// No ports (package).
// -----------------------------------------------------------------------------
package piso_tx_ctrl_pkg;

    typedef logic [1:0] state_t;

    // Fixed encodings so waveforms and legacy tooling can decode the state.
    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_GAP   = 2'b10;

    localparam int MAX_GAP   = 15;
    localparam int GAP_CNT_W = 4;

    // The gap counter counts down to zero, so it is loaded with GAP-1.
    // Out-of-range values saturate instead of wrapping the 4-bit counter.
    function automatic logic [GAP_CNT_W-1:0] gap_reload(input int gap);
        int g;
        g = (gap > MAX_GAP) ? MAX_GAP : gap;
        if (g <= 0) begin
            return '0;
        end
        return GAP_CNT_W'(g - 1);
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in / serial-out shift register. Load has priority over shift;
// vacated bit positions are zero-filled.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (clears the register)
//   load   in   capture d this edge
//   shift  in   advance one bit toward q this edge
//   d      in   [WIDTH] parallel word
//   q      out  current serial bit (bit WIDTH-1 when MSB_FIRST, else bit 0)
// -----------------------------------------------------------------------------
module piso_shift_reg
    import piso_tx_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] r_data;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of evaluation order.
    // NOTE: this data register is reset on purpose so a frame abandoned by
    // reset leaves no stale bits behind; pure data storage normally is not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                r_data <= {r_data[WIDTH-2:0], 1'b0};
            end else begin
                r_data <= {1'b0, r_data[WIDTH-1:1]};
            end
        end
    end

    assign q = (MSB_FIRST != 0) ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl
// Serializer controller: accepts parallel words on a valid/ready handshake,
// drives the load/shift controls of a PISO register, emits one bit per clock
// with frame start/end strobes, then inserts GAP idle cycles between frames.
// With GAP==0 a word can be accepted on the last bit of the current frame,
// giving a gapless back-to-back stream.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset; all outputs read 0 while low
//   in_valid     in   producer offers in_data
//   in_data      in   [WIDTH] word to serialize, captured on the transfer edge
//   in_ready     out  a word can be accepted this cycle
//   ser_out      out  serial data bit
//   ser_valid    out  ser_out carries a frame bit
//   frame_start  out  first bit of a frame
//   frame_end    out  last bit of a frame
//   busy         out  shifting or in the inter-frame gap
// -----------------------------------------------------------------------------
module piso_tx_ctrl
    import piso_tx_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_reload(GAP);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       w_bit_cnt_nxt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic [GAP_CNT_W-1:0]   w_gap_cnt_nxt;

    logic w_in_shift;
    logic w_in_gap;
    logic w_last_bit;
    logic w_ready;
    logic w_xfer;
    logic w_piso_q;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_in_gap   = (r_state == ST_GAP);
    assign w_last_bit = w_in_shift && (r_bit_cnt == '0);

    // Ready depends only on state/count (never on in_valid), so there is no
    // combinational path from in_valid back to in_ready. Gating with rst_n
    // keeps every output at 0 for the whole reset window.
    assign w_ready = rst_n && ((r_state == ST_IDLE) || ((GAP == 0) && w_last_bit));
    assign w_xfer  = in_valid && w_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a missing
        // default on any path would infer a latch.
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = LAST_IDX;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end else if (w_xfer) begin
                        // Reload in place: next frame starts next cycle.
                        w_bit_cnt_nxt = LAST_IDX;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Shift every SHIFT cycle; on a back-to-back reload, load wins inside
    // the shift register.
    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_xfer),
        .shift (w_in_shift),
        .d     (in_data),
        .q     (w_piso_q)
    );

    assign in_ready    = w_ready;
    assign ser_valid   = rst_n && w_in_shift;
    assign ser_out     = rst_n && w_in_shift && w_piso_q;
    // The count is reloaded to WIDTH-1 on every frame entry, so that value
    // marks the first bit.
    assign frame_start = rst_n && w_in_shift && (r_bit_cnt == LAST_IDX);
    assign frame_end   = rst_n && w_last_bit;
    assign busy        = rst_n && (w_in_shift || w_in_gap);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_ctrl
// Three controller instances with different MSB_FIRST/GAP settings share one
// clock and reset. A frame-level reference model (accepted word, bits left in
// the frame, gap cycles left) predicts every output of every instance each
// cycle; table vectors and hand sequences add explicit expectations.
// -----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

    localparam int N = 3;
    localparam int W = 4;
    localparam int MSB_CFG [N] = '{1, 0, 1};
    localparam int GAP_CFG [N] = '{1, 2, 0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid    [N];
    logic [W-1:0] in_data     [N];
    logic         in_ready    [N];
    logic         ser_out     [N];
    logic         ser_valid   [N];
    logic         frame_start [N];
    logic         frame_end   [N];
    logic         busy        [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        piso_tx_ctrl #(
            .WIDTH     (W),
            .MSB_FIRST (MSB_CFG[g]),
            .GAP       (GAP_CFG[g])
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid[g]),
            .in_data     (in_data[g]),
            .in_ready    (in_ready[g]),
            .ser_out     (ser_out[g]),
            .ser_valid   (ser_valid[g]),
            .frame_start (frame_start[g]),
            .frame_end   (frame_end[g]),
            .busy        (busy[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: word being sent, frame bits still to send, gap left.
    int           m_left [N];
    int           m_gap  [N];
    logic [W-1:0] m_word [N];
    logic         m_xfer [N];
    // Outputs sampled in the most recent cycle: {ready,sout,sval,fs,fe,busy}.
    logic [5:0]   smp    [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready(int i);
        return rst_n && ((m_left[i] == 0 && m_gap[i] == 0) ||
                         (GAP_CFG[i] == 0 && m_left[i] == 1));
    endfunction

    // Bit of the accepted word due now, from how many bits remain.
    function automatic logic exp_bit(int i);
        int idx;
        if (m_left[i] == 0) return 1'b0;
        idx = (MSB_CFG[i] != 0) ? m_left[i] - 1 : W - m_left[i];
        return m_word[i][idx];
    endfunction

    function automatic logic [5:0] exp_vec(int i);
        logic sv;
        sv = rst_n && (m_left[i] > 0);
        return {exp_ready(i), sv && exp_bit(i), sv, sv && (m_left[i] == W),
                sv && (m_left[i] == 1), rst_n && (m_left[i] > 0 || m_gap[i] > 0)};
    endfunction

    task automatic compare_all();
        string nm [6] = '{"busy", "frame_end", "frame_start", "ser_valid", "ser_out", "in_ready"};
        for (int i = 0; i < N; i++) begin
            logic [5:0] e;
            smp[i] = {in_ready[i], ser_out[i], ser_valid[i], frame_start[i], frame_end[i], busy[i]};
            e = exp_vec(i);
            for (int b = 0; b < 6; b++) begin
                check($sformatf("cyc%0d dut%0d %s", cyc, i, nm[b]), 32'(smp[i][b]), 32'(e[b]));
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            logic x;
            x = in_valid[i] && exp_ready(i);
            m_xfer[i] = x;
            if (!rst_n) begin
                m_left[i] = 0;
                m_gap[i]  = 0;
            end else begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_gap[i] = GAP_CFG[i];
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end
                if (x) begin
                    m_word[i] = in_data[i];
                    m_left[i] = W;
                end
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, then give
    // the caller a point 1 time unit after the edge to drive new inputs.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end
    endtask

    typedef struct {
        int         inst;
        logic       v;
        logic [W-1:0] d;
        logic [5:0] exp;   // {ready, sout, sval, fs, fe, busy}
    } vec_t;

    initial begin
        vec_t       vecs [$];
        int         n_acc;
        int         acc_cyc;
        int         fs_cnt;
        int         nbits;
        logic [7:0] sv_bits;
        logic [7:0] so_bits;
        logic [7:0] rd_bits;
        logic [5:0] or_acc;
        logic       and_rdy;

        // Frame of 0110, MSB first, GAP=1 on dut0.
        vecs.push_back('{0, 1'b1, 4'b0110, 6'b100000});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b001101});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b011001});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b011001});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b001011});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b000001});
        vecs.push_back('{0, 1'b0, 4'b0000, 6'b100000});
        // Frame of 1011, LSB first, GAP=2 on dut1: bits 1,1,0,1.
        vecs.push_back('{1, 1'b1, 4'b1011, 6'b100000});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b011101});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b011001});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b001001});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b011011});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b000001});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b000001});
        vecs.push_back('{1, 1'b0, 4'b0000, 6'b100000});

        for (int i = 0; i < N; i++) begin
            m_left[i] = 0;
            m_gap[i]  = 0;
            m_word[i] = '0;
            m_xfer[i] = 1'b0;
        end
        rst_n = 1'b0;
        idle_inputs();

        // Reset: all outputs low, including in_ready.
        cycle();
        cycle();
        for (int i = 0; i < N; i++) check($sformatf("reset outputs dut%0d", i), 32'(smp[i]), 32'd0);
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) check($sformatf("post-reset ready dut%0d", i), 32'(smp[i]), 32'b100000);

        // Table-driven frames.
        for (int k = 0; k < vecs.size(); k++) begin
            idle_inputs();
            in_valid[vecs[k].inst] = vecs[k].v;
            in_data[vecs[k].inst]  = vecs[k].d;
            cycle();
            check($sformatf("vec%0d dut%0d", k, vecs[k].inst), 32'(smp[vecs[k].inst]), 32'(vecs[k].exp));
        end
        idle_inputs();
        cycle();

        // GAP=0 back-to-back: 1111 then 0001 with in_valid held high.
        n_acc = 0; sv_bits = '0; so_bits = '0; rd_bits = '0;
        in_valid[2] = 1'b1;
        in_data[2]  = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            cycle();
            if (k >= 1) begin
                sv_bits = {sv_bits[6:0], smp[2][3]};
                so_bits = {so_bits[6:0], smp[2][4]};
                rd_bits = {rd_bits[6:0], smp[2][5]};
            end
            if (m_xfer[2]) begin
                n_acc++;
                if (n_acc == 1) in_data[2] = 4'b0001;
                else in_valid[2] = 1'b0;
            end
        end
        check("b2b words accepted", 32'(n_acc), 32'd2);
        check("b2b ser_valid run", 32'(sv_bits), 32'hFF);
        check("b2b bits", 32'(so_bits), 32'b11110001);
        check("b2b in_ready pattern", 32'(rd_bits), 32'b00010001);
        cycle();

        // in_valid held through SHIFT and GAP: accepted only once IDLE.
        n_acc = 0; acc_cyc = -1; fs_cnt = 0; nbits = 0; so_bits = '0;
        in_valid[0] = 1'b1;
        in_data[0]  = 4'b0011;
        for (int k = 0; k <= 14; k++) begin
            cycle();
            if (smp[0][3]) begin
                so_bits = {so_bits[6:0], smp[0][4]};
                nbits++;
            end
            if (smp[0][2]) fs_cnt++;
            if (m_xfer[0]) begin
                n_acc++;
                if (n_acc == 1) in_data[0] = 4'b1010;
                else begin
                    acc_cyc = k;
                    in_valid[0] = 1'b0;
                end
            end
        end
        check("held word accept cycle", 32'(acc_cyc), 32'd6);
        check("held words accepted", 32'(n_acc), 32'd2);
        check("held frame starts", 32'(fs_cnt), 32'd2);
        check("held bit count", 32'(nbits), 32'd8);
        check("held bits", 32'(so_bits), 32'b00111010);

        // Reset on the second bit of a frame.
        in_valid[0] = 1'b1;
        in_data[0]  = 4'b1001;
        cycle();
        in_valid[0] = 1'b0;
        cycle();
        check("mid-frame first bit valid", 32'(smp[0][3]), 32'd1);
        rst_n = 1'b0;
        cycle();
        check("mid-frame reset outputs", 32'(smp[0]), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("after reset idle", 32'(smp[0]), 32'b100000);
        in_valid[0] = 1'b1;
        in_data[0]  = 4'b0101;
        cycle();
        in_valid[0] = 1'b0;
        so_bits = '0; sv_bits = '0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            so_bits = {so_bits[6:0], smp[0][4]};
            sv_bits = {sv_bits[6:0], smp[0][3]};
        end
        check("after reset bits", 32'(so_bits), 32'h05);
        check("after reset ser_valid", 32'(sv_bits), 32'h0F);
        for (int k = 0; k < 3; k++) cycle();

        // Quiet inputs for 20 cycles.
        idle_inputs();
        or_acc = '0; and_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                or_acc  = or_acc | (smp[i] & 6'b001111);
                and_rdy = and_rdy & smp[i][5];
            end
        end
        check("idle strobes and busy", 32'(or_acc), 32'd0);
        check("idle in_ready", 32'(and_rdy), 32'd1);

        // Randomized traffic with occasional resets; the model checks each cycle.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = W'($urandom);
                end
            end
            cycle();
            for (int i = 0; i < N; i++) begin
                if (m_xfer[i]) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    in_data[i]  = W'($urandom);
                end
            end
        end
        rst_n = 1'b1;
        idle_inputs();
        for (int k = 0; k < 10; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
